perf_counter_bank: RTL and testbench

//   Parametrised bank of event counters for the pipelined CPU; generalises the single

---
 rtl/perf_counter_bank.sv | 97 +++++++++
 tb/tb_perf_counter_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of event counters with sticky overflow, halt freeze,
// atomic snapshot into shadow registers and a registered read port.
module perf_counter_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 2
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic [NUM_CH-1:0] i_event,
  input  logic [NUM_CH-1:0] i_clear,
  input  logic              i_halt,
  input  logic              i_snap,
  input  logic              i_rd_req,
  input  logic [SEL_W-1:0]  i_rd_sel,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_rd_valid,
  output logic [NUM_CH-1:0] o_ovf,
  output logic [WIDTH-1:0]  o_count0
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]  live_q   [NUM_CH];
  logic [WIDTH-1:0]  live_d   [NUM_CH];
  logic [WIDTH-1:0]  shadow_q [NUM_CH];
  logic [WIDTH-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  rd_data_d;
  logic              rd_valid_q;
  logic              rd_valid_d;

  // Clear beats event; snapshot always sees the pre-update live value.
  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      live_d[c]   = live_q[c];
      shadow_d[c] = i_snap ? live_q[c] : shadow_q[c];
      if (i_clear[c]) begin
        live_d[c] = '0;
        ovf_d[c]  = 1'b0;
      end else if (i_event[c] && !i_halt) begin
        if (live_q[c] == MAX) begin
          ovf_d[c] = 1'b1;
          if (SATURATE == 0) begin
            live_d[c] = '0;
          end
        end else begin
          live_d[c] = live_q[c] + WIDTH'(1);
        end
      end
    end
  end

  // Out-of-range selects answer with zero data.
  always_comb begin
    rd_valid_d = i_rd_req;
    rd_data_d  = rd_data_q;
    if (i_rd_req) begin
      rd_data_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_rd_sel == SEL_W'(c)) begin
          rd_data_d = shadow_q[c];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int c = 0; c < NUM_CH; c++) begin
        live_q[c]   <= '0;
        shadow_q[c] <= '0;
      end
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        live_q[c]   <= live_d[c];
        shadow_q[c] <= shadow_d[c];
      end
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_ovf      = ovf_q;
  assign o_count0   = live_q[0];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: wrap and saturate copies share stimulus;
// read responses are checked by a scoreboard monitor.
module tb_perf_counter_bank;

  logic       Clk;
  logic       Reset_N;
  logic [3:0] i_event;
  logic [3:0] i_clear;
  logic       i_halt;
  logic       i_snap;
  logic       i_rd_req;
  logic [2:0] i_rd_sel;

  logic [3:0] rd_data_w, rd_data_s;
  logic       rd_valid_w, rd_valid_s;
  logic [3:0] ovf_w, ovf_s;
  logic [3:0] count0_w, count0_s;

  int checks;
  int failures;
  int qw[$];
  int qs[$];

  perf_counter_bank #(
    .WIDTH(4), .NUM_CH(4), .SATURATE(0), .SEL_W(3)
  ) u_wrap (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_event(i_event), .i_clear(i_clear),
    .i_halt(i_halt), .i_snap(i_snap),
    .i_rd_req(i_rd_req), .i_rd_sel(i_rd_sel),
    .o_rd_data(rd_data_w), .o_rd_valid(rd_valid_w),
    .o_ovf(ovf_w), .o_count0(count0_w)
  );

  perf_counter_bank #(
    .WIDTH(4), .NUM_CH(4), .SATURATE(1), .SEL_W(3)
  ) u_sat (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_event(i_event), .i_clear(i_clear),
    .i_halt(i_halt), .i_snap(i_snap),
    .i_rd_req(i_rd_req), .i_rd_sel(i_rd_sel),
    .o_rd_data(rd_data_s), .o_rd_valid(rd_valid_s),
    .o_ovf(ovf_s), .o_count0(count0_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic ev(input logic [3:0] e, input int n);
    i_event = e;
    step(n);
    i_event = '0;
  endtask

  task automatic snap();
    i_snap = 1'b1;
    step();
    i_snap = 1'b0;
  endtask

  task automatic rd(input int sel, input int ew, input int es);
    i_rd_req = 1'b1;
    i_rd_sel = 3'(sel);
    qw.push_back(ew);
    qs.push_back(es);
    step();
    i_rd_req = 1'b0;
  endtask

  // Monitor: every valid response must match the oldest expectation.
  always @(negedge Clk) begin
    int e;
    if (rd_valid_w) begin
      if (qw.size() == 0) begin
        chk("wrap_unexpected_valid", 1, 0);
      end else begin
        e = qw.pop_front();
        chk("wrap_rd_data", int'(rd_data_w), e);
      end
    end
    if (rd_valid_s) begin
      if (qs.size() == 0) begin
        chk("sat_unexpected_valid", 1, 0);
      end else begin
        e = qs.pop_front();
        chk("sat_rd_data", int'(rd_data_s), e);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    Reset_N  = 1'b0;
    i_event  = '0;
    i_clear  = '0;
    i_halt   = 1'b0;
    i_snap   = 1'b0;
    i_rd_req = 1'b0;
    i_rd_sel = '0;
    step(3);
    chk("reset_count0", int'(count0_w), 0);
    chk("reset_ovf", int'(ovf_w), 0);
    chk("reset_valid", int'(rd_valid_w), 0);
    Reset_N = 1'b1;
    step();

    // Five events on ch0, snapshot, read back.
    ev(4'b0001, 5);
    chk("t1_count0_w", int'(count0_w), 5);
    chk("t1_count0_s", int'(count0_s), 5);
    snap();
    rd(0, 5, 5);
    step();

    // 17 events on ch1: wrap -> 1, saturate -> 15.
    ev(4'b0010, 17);
    chk("t2_ovf_w", int'(ovf_w), 2);
    chk("t2_ovf_s", int'(ovf_s), 2);
    chk("t2_count0", int'(count0_w), 5);
    snap();
    rd(1, 1, 15);

    // ch2 overflowed then cleared with a colliding event.
    ev(4'b0100, 16);
    chk("t3_ovf_set_w", int'(ovf_w), 6);
    chk("t3_ovf_set_s", int'(ovf_s), 6);
    ev(4'b0100, 7);
    i_clear = 4'b0100;
    ev(4'b0100, 1);
    i_clear = '0;
    chk("t3_ovf_clr_w", int'(ovf_w), 2);
    chk("t3_ovf_clr_s", int'(ovf_s), 2);
    snap();
    rd(2, 0, 0);
    ev(4'b0100, 1);
    snap();
    rd(2, 1, 1);

    // Halt freezes all channels.
    i_halt = 1'b1;
    ev(4'b1111, 4);
    i_halt = 1'b0;
    chk("t4_halt_count0", int'(count0_w), 5);
    snap();
    rd(3, 0, 0);
    rd(2, 1, 1);
    ev(4'b1111, 2);
    chk("t4_resume_count0", int'(count0_w), 7);
    snap();
    rd(1, 3, 15);
    rd(3, 2, 2);
    rd(0, 7, 7);
    step();

    // Event, snapshot and read on one edge: read sees old shadow.
    ev(4'b1000, 7);
    i_event  = 4'b1000;
    i_snap   = 1'b1;
    i_rd_req = 1'b1;
    i_rd_sel = 3'd3;
    qw.push_back(2);
    qs.push_back(2);
    step();
    i_event  = '0;
    i_snap   = 1'b0;
    i_rd_req = 1'b0;
    rd(3, 9, 9);
    snap();
    rd(3, 10, 10);
    step();
    chk("t5_hold_data", int'(rd_data_w), 10);
    chk("t5_hold_valid", int'(rd_valid_w), 0);
    rd(4, 0, 0);
    rd(7, 0, 0);
    step();

    // Async reset between request and next edge drops the response.
    i_rd_req = 1'b1;
    i_rd_sel = 3'd0;
    #2;
    Reset_N = 1'b0;
    #1;
    chk("t6_valid_w", int'(rd_valid_w), 0);
    chk("t6_ovf_w", int'(ovf_w), 0);
    chk("t6_ovf_s", int'(ovf_s), 0);
    chk("t6_count0_w", int'(count0_w), 0);
    chk("t6_count0_s", int'(count0_s), 0);
    i_rd_req = 1'b0;
    step(2);
    Reset_N = 1'b1;
    step(2);
    chk("t6_post_count0", int'(count0_w), 0);
    rd(1, 0, 0);
    snap();
    rd(0, 0, 0);
    step(3);

    chk("queue_w_drained", qw.size(), 0);
    chk("queue_s_drained", qs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
